// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding data-memory responder with fixed response latency.
// Loads and stores of byte/half/word size, with sign or zero extension on loads.
// Optional feature: define DMEM_RESP_MISALIGN_CHK_EN to fault misaligned half/word accesses.
module dmem_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_bhw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_n;
    logic [2:0]         cnt, cnt_n;
    logic               run;
    logic               accept;

    logic               r_we;
    logic [2:0]         r_bhw;
    logic [ADDR_W-1:0]  r_idx;
    logic [1:0]         r_off;
    logic [31:0]        r_wdata;

    logic [31:0]        mem [2**ADDR_W];
    logic [31:0]        rd_word, wr_word, ld_val;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic               bad, wr_en;

    // Address bits above the word index are deliberately ignored (wrap-around).
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:ADDR_W+2]};

    // State register, latency counter and post-reset run flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            run   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            run   <= 1'b1;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = req_valid && run && (state == IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_n   = 3'(LATENCY - 1);
                    state_n = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt <= 3'd1) begin
                    cnt_n   = '0;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request fields captured on accept and held through the response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_bhw   <= '0;
            r_idx   <= '0;
            r_off   <= '0;
            r_wdata <= '0;
        end else if (accept) begin
            r_we    <= req_we;
            r_bhw   <= req_bhw;
            r_idx   <= req_addr[ADDR_W+1:2];
            r_off   <= req_addr[1:0];
            r_wdata <= req_wdata;
        end
    end

    // Fault decode, load extraction and store merge for the held request.
    always_comb begin
        case (r_bhw)
            3'b000, 3'b001, 3'b010: bad = 1'b0;
            3'b100, 3'b101:         bad = r_we;
            default:                bad = 1'b1;
        endcase
`ifdef DMEM_RESP_MISALIGN_CHK_EN
        if ((r_bhw[1:0] == 2'b01) && r_off[0])
            bad = 1'b1;
        if ((r_bhw[1:0] == 2'b10) && (r_off != 2'b00))
            bad = 1'b1;
`endif
        rd_word = mem[r_idx];
        ld_byte = rd_word[{r_off, 3'b000} +: 8];
        ld_half = r_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (r_bhw[1:0])
            2'b00:   ld_val = {{24{~r_bhw[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{~r_bhw[2] & ld_half[15]}}, ld_half};
            default: ld_val = rd_word;
        endcase
        wr_word = rd_word;
        case (r_bhw[1:0])
            2'b00: wr_word[{r_off, 3'b000} +: 8] = r_wdata[7:0];
            2'b01: begin
                if (r_off[1])
                    wr_word[31:16] = r_wdata[15:0];
                else
                    wr_word[15:0] = r_wdata[15:0];
            end
            default: wr_word = r_wdata;
        endcase
        wr_en = (state == RESP) && r_we && !bad;
    end

    // Store commit at the end of the response cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[r_idx] <= wr_word;
    end

    // Handshake and response outputs, forced to zero outside the response pulse.
    always_comb begin
        req_ready  = run && (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = resp_valid && bad;
        resp_data  = (resp_valid && !r_we && !bad) ? ld_val : '0;
    end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: scoreboard bench for dmem_resp against a byte-array memory model.
module tb_dmem_resp;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 2;
    localparam int NBYTES  = 4 * (1 << ADDR_W);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_bhw;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    dmem_resp #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_bhw(req_bhw), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mb [NBYTES];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    // Reference: byte-addressed memory, access sizes and extension rules applied directly.
    function automatic void model(input logic we, input logic [2:0] bhw, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] d, output logic e);
        int unsigned b, n;
        bit sgn;
        logic [31:0] val;
        b = addr & (NBYTES - 1);
        e = 1'b0; d = '0; n = 1; sgn = 1'b0;
        case (bhw)
            3'd0: begin n = 1; sgn = 1'b1; end
            3'd1: begin n = 2; sgn = 1'b1; end
            3'd2: begin n = 4; end
            3'd4: begin n = 1; e = we; end
            3'd5: begin n = 2; e = we; end
            default: e = 1'b1;
        endcase
`ifdef DMEM_RESP_MISALIGN_CHK_EN
        if (n > 1 && (b % n) != 0) e = 1'b1;
`endif
        if (e) return;
        b = b - (b % n);
        if (we) begin
            for (int unsigned i = 0; i < n; i++) mb[b + i] = wd[8*i +: 8];
        end else begin
            val = '0;
            for (int unsigned i = 0; i < n; i++) val = val | (32'(mb[b + i]) << (8*i));
            if (sgn && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
            d = val;
        end
    endfunction

    // mode 0: expect model result; 1: expect given constants (model still updated); 2: aborted, no expectation.
    task automatic issue(input logic we, input logic [2:0] bhw, input logic [31:0] addr,
                         input logic [31:0] wd, input int mode,
                         input logic [31:0] ed, input logic ee);
        int t = 0;
        exp_t x;
        logic [31:0] md;
        logic me;
        req_valid = 1'b1; req_we = we; req_bhw = bhw; req_addr = addr; req_wdata = wd;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check(1'b0, "accept_timeout", 64'(t), 64'(20));
        end else begin
            last_acc = cyc;
            if (mode != 2) begin
                model(we, bhw, addr, wd, md, me);
                x.data = (mode == 1) ? ed : md;
                x.err  = (mode == 1) ? ee : me;
                x.cyc  = cyc + LATENCY;
                sb.push_back(x);
            end
        end
        @(negedge clk);
    endtask

    // Monitor: compare every response against the scoreboard, and idle outputs against zero.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_resp", {32'(resp_err), resp_data}, 64'(0));
                end else begin
                    x = sb.pop_front();
                    check(resp_data == x.data, "resp_data", resp_data, x.data);
                    check(resp_err == x.err, "resp_err", resp_err, x.err);
                    check(cyc == x.cyc, "resp_cycle", 64'(cyc), 64'(x.cyc));
                end
            end else begin
                check(resp_data == 0 && resp_err == 0, "idle_zero", {32'(resp_err), resp_data}, 64'(0));
            end
            if (!rst_n)
                check(!req_ready && !resp_valid, "reset_outputs", {req_ready, resp_valid}, 64'(0));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] lo, hi, d;
        int prev;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_bhw = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check(req_ready == 1'b1, "ready_after_reset", req_ready, 1);

        // Initialise the test region (words 0..15) with random words.
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 3'd2, 32'(4*i), $urandom, 0, '0, 1'b0);
            req_valid = 1'b0;
        end

        // Directed scenarios.
        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0); req_valid = 1'b0;
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0); req_valid = 1'b0;
        issue(1'b0, 3'd0, 32'h13, 32'h0, 1, 32'hFFFFFFDE, 1'b0); req_valid = 1'b0;
        issue(1'b0, 3'd4, 32'h13, 32'h0, 1, 32'h000000DE, 1'b0); req_valid = 1'b0;
        issue(1'b0, 3'd1, 32'h10, 32'h0, 1, 32'hFFFFBEEF, 1'b0); req_valid = 1'b0;
        issue(1'b0, 3'd5, 32'h12, 32'h0, 1, 32'h0000DEAD, 1'b0); req_valid = 1'b0;
        issue(1'b1, 3'd0, 32'h11, 32'h12345677, 1, 32'h0, 1'b0); req_valid = 1'b0;
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1, 32'hDEAD77EF, 1'b0); req_valid = 1'b0;
`ifdef DMEM_RESP_MISALIGN_CHK_EN
        issue(1'b0, 3'd2, 32'h12, 32'h0, 1, 32'h0, 1'b1); req_valid = 1'b0;
`else
        issue(1'b0, 3'd2, 32'h12, 32'h0, 1, 32'hDEAD77EF, 1'b0); req_valid = 1'b0;
`endif
        // Illegal encodings: load/store faults with no write.
        issue(1'b0, 3'd3, 32'h10, 32'h0, 1, 32'h0, 1'b1); req_valid = 1'b0;
        issue(1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 1, 32'h0, 1'b1); req_valid = 1'b0;
        issue(1'b1, 3'd7, 32'h10, 32'hFFFFFFFF, 1, 32'h0, 1'b1); req_valid = 1'b0;
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1, 32'hDEAD77EF, 1'b0); req_valid = 1'b0;

        // Store aborted by reset one cycle after accept; old contents must remain.
        issue(1'b1, 3'd2, 32'h20, 32'h1, 2, '0, 1'b0);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check(req_ready == 1'b1, "ready_after_abort", req_ready, 1);
        issue(1'b0, 3'd2, 32'h20, 32'h0, 0, '0, 1'b0); req_valid = 1'b0;

        // Continuous valid: accepts spaced LATENCY+1 cycles apart.
        issue(1'b0, 3'd2, 32'h4, 32'h0, 0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            prev = last_acc;
            issue(1'b0, 3'(i % 3), 32'(4*i + i), 32'h0, 0, '0, 1'b0);
            check(last_acc - prev == LATENCY + 1, "accept_spacing", 64'(last_acc - prev), 64'(LATENCY + 1));
        end
        req_valid = 1'b0;

        // Randomised traffic over the initialised region, with aliased upper address bits.
        for (int i = 0; i < 150; i++) begin
            lo = 32'($urandom_range(0, 63));
            hi = $urandom & ~32'(NBYTES - 1);
            d  = $urandom;
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), hi | lo, d, 0, '0, 1'b0);
            req_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
        check(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; memory holds 2^ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..7.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  1  memory-FU request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_bhw  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-009 req_addr  input  32  byte address, already summed (rs1 + imm) by requester.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_data  output  32  load result, valid only with resp_valid.
REQ-013 resp_err  output  1  access fault, valid only with resp_valid.

Function
REQ-014 FSM states IDLE, WAIT, RESP; IDLE -> WAIT on accept (LATENCY>1), IDLE -> RESP on accept (LATENCY=1), WAIT -> RESP when down-counter reaches 1, RESP -> IDLE unconditionally.
REQ-015 req_ready = 1 only in IDLE; accept = req_valid & req_ready; request fields are registered on accept and held until RESP ends.
REQ-016 resp_valid asserted exactly LATENCY cycles after the accept edge, for exactly one cycle; no backpressure.
REQ-017 Back-to-back: the earliest next accept is the cycle after RESP (throughput one request per LATENCY+1 cycles).
REQ-018 Word index = addr[ADDR_W+1:2]; higher address bits ignored (wrap-around).
REQ-019 Load: word read in the RESP cycle; LB/LBU select byte addr[1:0], LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-020 Store: write committed at the RESP-cycle edge only; SB writes lane addr[1:0] with wdata[7:0], SH writes lanes of half addr[1] with wdata[15:0], SW writes all lanes; other lanes unchanged.
REQ-021 Store response: resp_data = 0, resp_err = 0 unless a fault applies.
REQ-022 Illegal req_bhw (011, 110, 111; or 100/101 with req_we = 1): resp_err = 1, resp_data = 0, no write.
REQ-023 Load issued after a store response observes the stored data (no stale read).
REQ-024 resp_data and resp_err are 0 whenever resp_valid = 0.

Reset
REQ-025 rst_n low forces state IDLE, counter 0, resp_valid 0, resp_data 0, resp_err 0, req_ready 0 while low; req_ready 1 from the first edge after release.
REQ-026 Reset during WAIT or RESP aborts the request: no write commits, no response is produced.
REQ-027 Memory contents are not cleared by reset.

Configuration
REQ-028 Macro DMEM_RESP_MISALIGN_CHK_EN defined: half access with addr[0] = 1 or word access with addr[1:0] != 0 gives resp_err = 1, resp_data = 0, no write.
REQ-029 Macro undefined: misaligned low address bits are ignored (half uses addr[1], word uses the word index), the access proceeds normally, and resp_err reflects only REQ-022.

Verification
REQ-030 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_valid exactly 2 cycles after each accept, read returns 0xDEADBEEF, err 0.
REQ-031 After REQ-030: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-032 SB 0x11 data 0x12345677, then LW 0x10 -> 0xDEAD77EF.
REQ-033 LW 0x12 with macro defined -> err 1, data 0; macro undefined -> returns word 0x10 contents, err 0.
REQ-034 SW 0x20 data 0x1, drop rst_n one cycle after accept, then LW 0x20 -> old contents, no response for the aborted store.
REQ-035 req_valid held high continuously -> accepts spaced LATENCY+1 cycles, req_ready low in WAIT/RESP; LATENCY=1 build gives resp 1 cycle after accept.
